// File: rtl/instruction_decode.sv
// MIPS ID stage: register file, control decode, J/JAL/JR redirect, load-use stall, ID/EX register.
// Optional macro ID_WB_BYPASS_EN: same-cycle write-through from WB to both read ports.
module instruction_decode #(
   parameter int len   = 32,
   parameter int nregs = 32
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [len-1:0] in_pc_branch,
   input  logic [len-1:0] in_instruction,
   input  logic           in_flush,
   input  logic           in_ex_mem_read,
   input  logic [4:0]     in_ex_rt,
   input  logic           in_wb_reg_write,
   input  logic [4:0]     in_wb_addr,
   input  logic [len-1:0] in_wb_data,
   output logic [1:0]     out_pc_src,
   output logic [len-1:0] out_pc_jump,
   output logic [len-1:0] out_pc_register,
   output logic           out_stall,
   output logic [len-1:0] out_pc_next,
   output logic [len-1:0] out_reg1,
   output logic [len-1:0] out_reg2,
   output logic [len-1:0] out_sign_ext,
   output logic [4:0]     out_rs,
   output logic [4:0]     out_rt,
   output logic [4:0]     out_rd,
   output logic [4:0]     out_shamt,
   output logic [5:0]     out_opcode,
   output logic [5:0]     out_funct,
   output logic           out_reg_dst,
   output logic           out_alu_src,
   output logic           out_mem_read,
   output logic           out_mem_write,
   output logic           out_reg_write,
   output logic           out_mem_to_reg,
   output logic           out_link
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   logic [5:0] opcode, funct;
   logic [4:0] rs, rt, rd, shamt;
   assign opcode = in_instruction[31:26];
   assign rs     = in_instruction[25:21];
   assign rt     = in_instruction[20:16];
   assign rd     = in_instruction[15:11];
   assign shamt  = in_instruction[10:6];
   assign funct  = in_instruction[5:0];

   logic [len-1:0] regs [nregs];
   logic [len-1:0] rs_val, rt_val, sign_ext;
   logic           squash_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < nregs; i++) regs[i] <= '0;
      end else if (in_wb_reg_write && in_wb_addr != 5'd0) begin
         regs[in_wb_addr] <= in_wb_data;
      end
   end

`ifdef ID_WB_BYPASS_EN
   assign rs_val = (rs == 5'd0) ? '0 :
                   (in_wb_reg_write && in_wb_addr == rs) ? in_wb_data : regs[rs];
   assign rt_val = (rt == 5'd0) ? '0 :
                   (in_wb_reg_write && in_wb_addr == rt) ? in_wb_data : regs[rt];
`else
   assign rs_val = (rs == 5'd0) ? '0 : regs[rs];
   assign rt_val = (rt == 5'd0) ? '0 : regs[rt];
`endif

   assign sign_ext = {{(len-16){in_instruction[15]}}, in_instruction[15:0]};

   logic dec_reg_dst, dec_alu_src, dec_mem_read, dec_mem_write;
   logic dec_reg_write, dec_mem_to_reg, dec_link, is_j, is_jr;
   logic [4:0] dec_rd;

   // Unknown opcodes fall through with all control low, i.e. a bubble.
   always_comb begin
      dec_reg_dst    = 1'b0;
      dec_alu_src    = 1'b0;
      dec_mem_read   = 1'b0;
      dec_mem_write  = 1'b0;
      dec_reg_write  = 1'b0;
      dec_mem_to_reg = 1'b0;
      dec_link       = 1'b0;
      is_j           = 1'b0;
      is_jr          = 1'b0;
      dec_rd         = rd;
      case (opcode)
         OP_RTYPE: begin
            if (funct == FN_JR) begin
               is_jr = 1'b1;
            end else begin
               dec_reg_dst   = 1'b1;
               dec_reg_write = 1'b1;
            end
         end
         OP_LW: begin
            dec_alu_src    = 1'b1;
            dec_mem_read   = 1'b1;
            dec_mem_to_reg = 1'b1;
            dec_reg_write  = 1'b1;
         end
         OP_SW: begin
            dec_alu_src   = 1'b1;
            dec_mem_write = 1'b1;
         end
         OP_J:  is_j = 1'b1;
         OP_JAL: begin
            is_j          = 1'b1;
            dec_reg_write = 1'b1;
            dec_link      = 1'b1;
            dec_rd        = 5'd31;
         end
         OP_BEQ, OP_BNE: ;
         default: begin
            if (opcode[5:3] == 3'b001) begin
               dec_alu_src   = 1'b1;
               dec_reg_write = 1'b1;
            end
         end
      endcase
   end

   // Flush beats everything; the wrong-path slot after a jump never stalls.
   logic hazard, bubble;
   assign hazard    = in_ex_mem_read && in_ex_rt != 5'd0 && (in_ex_rt == rs || in_ex_rt == rt);
   assign out_stall = hazard && !in_flush && !squash_q;
   assign bubble    = in_flush || squash_q || out_stall;

   always_comb begin
      out_pc_src = 2'b00;
      if (!bubble) begin
         if (is_jr)     out_pc_src = 2'b11;
         else if (is_j) out_pc_src = 2'b10;
      end
   end

   assign out_pc_jump     = {in_pc_branch[len-1 -: 4], in_instruction[25:0], 2'b00};
   assign out_pc_register = rs_val;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) squash_q <= 1'b0;
      else        squash_q <= out_pc_src[1];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset || bubble) begin
         out_pc_next    <= '0;
         out_reg1       <= '0;
         out_reg2       <= '0;
         out_sign_ext   <= '0;
         out_rs         <= '0;
         out_rt         <= '0;
         out_rd         <= '0;
         out_shamt      <= '0;
         out_opcode     <= '0;
         out_funct      <= '0;
         out_reg_dst    <= 1'b0;
         out_alu_src    <= 1'b0;
         out_mem_read   <= 1'b0;
         out_mem_write  <= 1'b0;
         out_reg_write  <= 1'b0;
         out_mem_to_reg <= 1'b0;
         out_link       <= 1'b0;
      end else begin
         out_pc_next    <= in_pc_branch;
         out_reg1       <= rs_val;
         out_reg2       <= rt_val;
         out_sign_ext   <= sign_ext;
         out_rs         <= rs;
         out_rt         <= rt;
         out_rd         <= dec_rd;
         out_shamt      <= shamt;
         out_opcode     <= opcode;
         out_funct      <= funct;
         out_reg_dst    <= dec_reg_dst;
         out_alu_src    <= dec_alu_src;
         out_mem_read   <= dec_mem_read;
         out_mem_write  <= dec_mem_write;
         out_reg_write  <= dec_reg_write;
         out_mem_to_reg <= dec_mem_to_reg;
         out_link       <= dec_link;
      end
   end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- MIPS ID stage; sits directly downstream of the fetch stage.
- Consumes fetched instruction and PC+4; reads the 32x32 register file; decodes control; sign-extends the immediate.
- Resolves J/JAL/JR targets back to fetch; detects load-use hazards.
- Drives registered ID/EX outputs to the execute stage.

Parameters:
len, 32, datapath/instruction/PC width
nregs, 32, register file depth (address width fixed at 5)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
in_pc_branch  input  len  PC+4 of the instruction being decoded
in_instruction  input  len  fetched instruction
in_flush  input  1  squash current decode (taken branch resolved downstream)
in_ex_mem_read  input  1  instruction in EX is a load
in_ex_rt  input  5  destination reg of the instruction in EX
in_wb_reg_write  input  1  writeback enable
in_wb_addr  input  5  writeback register
in_wb_data  input  len  writeback data
out_pc_src  output  2  to fetch mux: 00 PC+4, 01 branch, 10 jump, 11 register
out_pc_jump  output  len  {in_pc_branch[31:28], instr[25:0], 2'b00}
out_pc_register  output  len  rs read value (JR target)
out_stall  output  1  hold PC and fetch output this cycle
out_pc_next  output  len  registered PC+4
out_reg1, out_reg2  output  len  registered rs/rt values
out_sign_ext  output  len  registered sign-extended imm[15:0]
out_rs, out_rt, out_rd  output  5  registered fields (out_rd = 31 for JAL)
out_shamt  output  5  registered instr[10:6]
out_opcode, out_funct  output  6  registered instr[31:26] / instr[5:0]
out_reg_dst, out_alu_src, out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg, out_link  output  1 each  registered control

Behaviour:
- Reset (reset=0, async): all registered outputs 0; all registers 0; squash flag 0.
- out_pc_src, out_pc_jump, out_pc_register and out_stall are combinational.
- Register file:
  - Write on posedge clk when in_wb_reg_write=1 and in_wb_addr!=0.
  - R0 always reads 0; reads are combinational.
- Decode classes:
  - R-type (op 000000): reg_dst=1, reg_write=1.
  - JR (op 0, funct 001000): no writes; pc_src=11.
  - lw (100011): alu_src, mem_read, mem_to_reg, reg_write.
  - sw (101011): alu_src, mem_write.
  - addi/andi/ori/xori/slti (001xxx): alu_src, reg_write.
  - beq/bne (00010x): no writes; target computed in EX.
  - J (000010): pc_src=10.
  - JAL (000011): pc_src=10, reg_write=1, link=1, out_rd=31.
  - Unknown opcode: bubble (all control 0).
- Hazard: stall=1 when in_ex_mem_read=1, in_ex_rt!=0 and in_ex_rt equals rs or rt of the current instruction.
  - On stall: ID/EX loads a bubble (all control 0; data fields don't-care, implement as 0).
  - On stall: pc_src forced 00, so a jump is not issued until the stall clears.
- Squash: when a jump issues (pc_src 10/11 and no stall), the internal squash flag sets for exactly one cycle.
  - Next cycle the arriving instruction (wrong-path PC+4) is treated as a bubble: pc_src=00, stall=0.
  - The flag then clears.
- in_flush=1: current decode becomes a bubble, pc_src=00, squash flag cleared.
  - in_flush has priority over stall and jump.
- Pipeline latency: one cycle from in_instruction to registered outputs. Registers update every cycle; no enable beyond the bubble insertion.
- Reset mid-operation: immediate clear, including pending squash.

Optional Feature:
- ID_WB_BYPASS_EN defined: write-through read.
  - If in_wb_reg_write=1 and in_wb_addr equals a nonzero read address, that port returns in_wb_data in the same cycle.
  - Applies to out_pc_register as well.
- Undefined: reads return the stored value only; the new value is visible the cycle after the write.

Test Plan:
- Release reset, instruction 0x014B4820 (add r9,r10,r11) with r10=5, r11=7 preloaded via WB -> next cycle out_reg1=5, out_reg2=7, out_rd=9, reg_dst=1, reg_write=1.
- lw in EX with in_ex_rt=10; decode add r9,r10,r11 -> out_stall=1, out_pc_src=00, next-cycle outputs all-zero control; stall drops when in_ex_mem_read=0.
- J 0x0000040 at in_pc_branch=0x00000104 -> out_pc_src=10, out_pc_jump=0x00000100; following cycle's instruction is bubbled with pc_src=00.
- JR r31 (r31=0x80) while WB writes r31=0x90 same cycle -> out_pc_register=0x90 with ID_WB_BYPASS_EN, 0x80 without.
- in_flush=1 together with a JAL decode -> out_pc_src=00, next-cycle reg_write=0, link=0; no squash the cycle after.
- WB write to r0 with data 0xFFFFFFFF, then read r0 -> out_reg1=0; assert reset mid-stream -> all outputs 0 immediately.
